fp_logit: RTL and testbench

- Inverse of the Q8.24 piecewise-linear sigmoid activation: maps a probability y back to its pre-activation x (logit).
- Uses the same nine-segment slope/intercept table as the forward sigmoid, so sigmoid(fp_logit(y)) ≈ y within the table's error.
- Sits on the backward/calibration path next to the neuron's activation stage.
- Iterative: one segment-select cycle, then one quotient bit per cycle through a restoring divider, with valid/ready handshakes on both sides.

---
 rtl/fp_logit_pkg.sv | 65 ++++++
 rtl/fp_seq_divider.sv | 85 ++++++++
 rtl/fp_logit.sv | 171 +++++++++++++++++
 tb/tb_fp_logit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_logit_pkg.sv
// Shared constants, state encoding and segment table for the fp_logit block.
// Optional guard-bit rounding is enabled by defining FP_LOGIT_ROUND_EN.
package fp_logit_pkg;

    localparam int Q  = 24;
    localparam int N  = 32;
    localparam int QB = Q + 4;
`ifdef FP_LOGIT_ROUND_EN
    localparam int QBITS = QB + 1;
`else
    localparam int QBITS = QB;
`endif
    // Dividend is the Q-bit numerator shifted up by Q plus any guard bit.
    localparam int DW = Q + Q + (QBITS - QB);

    localparam logic [N-2:0] HALF  = 31'd8388608;
    localparam logic [N-2:0] ONE   = 31'd16777216;
    localparam logic [N-2:0] SAT_8 = 31'd134217728;

    localparam logic [N-2:0] Y_B1 = 31'd12396685;
    localparam logic [N-2:0] Y_B2 = 31'd14886592;
    localparam logic [N-2:0] Y_B3 = 31'd16056635;
    localparam logic [N-2:0] Y_B4 = 31'd16652561;

    localparam logic [N-2:0] INTERCEPT5 = 31'd8388608;
    localparam logic [N-2:0] INTERCEPT6 = 31'd9906778;
    localparam logic [N-2:0] INTERCEPT7 = 31'd12546170;
    localparam logic [N-2:0] INTERCEPT8 = 31'd14865117;
    localparam logic [N-2:0] INTERCEPT9 = 31'd16462643;

    localparam logic [Q-1:0] SLOPE5 = 24'd4008077;
    localparam logic [Q-1:0] SLOPE6 = 24'd2489907;
    localparam logic [Q-1:0] SLOPE7 = 24'd1170211;
    localparam logic [Q-1:0] SLOPE8 = 24'd397117;
    localparam logic [Q-1:0] SLOPE9 = 24'd42279;

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    typedef struct packed {
        logic [N-2:0] b;
        logic [Q-1:0] m;
    } seg_t;

    function automatic seg_t seg_sel(input logic [N-2:0] yp);
        seg_t s;
        if (yp < Y_B1) begin
            s.b = INTERCEPT5;
            s.m = SLOPE5;
        end else if (yp < Y_B2) begin
            s.b = INTERCEPT6;
            s.m = SLOPE6;
        end else if (yp < Y_B3) begin
            s.b = INTERCEPT7;
            s.m = SLOPE7;
        end else if (yp < Y_B4) begin
            s.b = INTERCEPT8;
            s.m = SLOPE8;
        end else begin
            s.b = INTERCEPT9;
            s.m = SLOPE9;
        end
        return s;
    endfunction

endpackage

// File: rtl/fp_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first.
// The dividend bits above the quotient seed the remainder; ovf flags a quotient that would not fit.
module fp_seq_divider #(
    parameter int WD = 48,
    parameter int WM = 24,
    parameter int QW = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WD-1:0] dividend,
    input  logic [WM-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [QW-1:0] quotient
);

    localparam int HW = WD - QW;
    localparam int CW = $clog2(QW);

    logic [WM-1:0] rem_r;
    logic [WM-1:0] dvs_r;
    logic [QW-1:0] quo_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic          ovf_r;

    logic [WM:0]   trial_s;
    logic [WM:0]   diff_s;
    logic [WM-1:0] rem_next_s;
    logic          qbit_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        trial_s = {rem_r, quo_r[QW-1]};
        diff_s  = trial_s - {1'b0, dvs_r};
        if (trial_s >= {1'b0, dvs_r}) begin
            qbit_s     = 1'b1;
            rem_next_s = diff_s[WM-1:0];
        end else begin
            qbit_s     = 1'b0;
            rem_next_s = trial_s[WM-1:0];
        end
    end

    // Load on start, then iterate with the counter running QW-1 down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {WM{1'b0}};
            dvs_r  <= {WM{1'b0}};
            quo_r  <= {QW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (start) begin
            rem_r  <= {{(WM-HW){1'b0}}, dividend[WD-1:QW]};
            dvs_r  <= divisor;
            quo_r  <= dividend[QW-1:0];
            cnt_r  <= CW'(QW-1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
            ovf_r  <= ({{(WM-HW){1'b0}}, dividend[WD-1:QW]} >= divisor);
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[QW-2:0], qbit_s};
            if (cnt_r == {CW{1'b0}}) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ovf      = ovf_r;
    assign quotient = quo_r;

endmodule

// File: rtl/fp_logit.sv
// Inverse piecewise-linear sigmoid (logit) in sign-magnitude Q8.24, iterative divide.
// Define FP_LOGIT_ROUND_EN for a guard bit and half-up rounding (one extra cycle).
module fp_logit
    import fp_logit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x,
    output logic         err
);

    state_t       state_r;
    logic [N-1:0] y_r;
    logic         sign_r;
    logic         sat_r;
    logic         rng_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [N-1:0] x_r;
    logic         err_r;

    logic [N-2:0] mag_s;
    logic [N-2:0] yp_s;
    logic         neg_s;
    logic         mir_s;
    logic         sat_s;
    logic         sign_s;
    logic         rng_s;
    seg_t         seg_s;
    logic [Q-1:0] num_s;

    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic             div_ovf_s;
    logic [QBITS-1:0] quo_s;
    logic [QBITS-1:0] qr_s;
    logic [N-2:0]     qe_s;
    logic [N-2:0]     mag_out_s;
    logic [N-1:0]     x_s;

    // Mirror around 0.5, pick the segment and form the clamped numerator.
    always_comb begin
        mag_s = y_r[N-2:0];
        neg_s = y_r[N-1] && (mag_s != {(N-1){1'b0}});
        if (mag_s < HALF) begin
            yp_s  = ONE - mag_s;
            mir_s = 1'b1;
        end else begin
            yp_s  = mag_s;
            mir_s = 1'b0;
        end
        seg_s = seg_sel(yp_s);
        if (neg_s || (yp_s >= ONE)) begin
            sat_s = 1'b1;
            num_s = {Q{1'b0}};
        end else if (yp_s < seg_s.b) begin
            sat_s = 1'b0;
            num_s = {Q{1'b0}};
        end else begin
            sat_s = 1'b0;
            num_s = Q'(yp_s - seg_s.b);
        end
        sign_s = neg_s | mir_s;
        rng_s  = neg_s | (mag_s > ONE);
    end

    assign div_start_s = (state_r == PREP);

    fp_seq_divider #(
        .WD(DW),
        .WM(Q),
        .QW(QBITS)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend ({num_s, {(DW-Q){1'b0}}}),
        .divisor  (seg_s.m),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .ovf      (div_ovf_s),
        .quotient (quo_s)
    );

    // Result magnitude: optional rounding, saturation at 8.0, no negative zero.
    always_comb begin
`ifdef FP_LOGIT_ROUND_EN
        qr_s = {1'b0, quo_s[QBITS-1:1]} + {{(QBITS-1){1'b0}}, quo_s[0]};
`else
        qr_s = quo_s;
`endif
        qe_s = {{(N-1-QBITS){1'b0}}, qr_s};
        if (sat_r || div_ovf_s || (qe_s >= SAT_8)) begin
            mag_out_s = SAT_8;
        end else begin
            mag_out_s = qe_s;
        end
        if (mag_out_s == {(N-1){1'b0}}) begin
            x_s = {1'b0, mag_out_s};
        end else begin
            x_s = {sign_r, mag_out_s};
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            y_r         <= {N{1'b0}};
            sign_r      <= 1'b0;
            sat_r       <= 1'b0;
            rng_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            x_r         <= {N{1'b0}};
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        y_r        <= y;
                        in_ready_r <= 1'b0;
                        state_r    <= PREP;
                    end
                end
                PREP: begin
                    sign_r  <= sign_s;
                    sat_r   <= sat_s;
                    rng_r   <= rng_s;
                    state_r <= DIV;
                end
                DIV: begin
                    if (div_done_s) begin
                        x_r         <= x_s;
                        err_r       <= rng_r;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else if (!div_busy_s) begin
                        // Divider lost its operation: recover rather than hang.
                        in_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign x         = x_r;
    assign err       = err_r;

endmodule

// File: tb/tb_fp_logit.sv
// Directed self-checking bench for fp_logit; expected values come from hand-derived
// constants and an independent real-valued table with a 64-bit division model.
module tb_fp_logit;

    localparam int QB = 28;
`ifdef FP_LOGIT_ROUND_EN
    localparam int LAT = QB + 3;
`else
    localparam int LAT = QB + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_logit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .err       (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp, input int tol = 0);
        longint d;
        n_cmp++;
        d = longint'(got) - longint'(exp);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint rnd(input real v);
        return longint'($rtoi(v * 16777216.0 + 0.5));
    endfunction

    // Golden logit: returns {err, x}.
    function automatic logic [32:0] golden(input logic [31:0] yv);
        longint mag, yp, b, m, num, q;
        logic   s, e;
        mag = longint'(yv[30:0]);
        if (yv[31] && (mag != 0)) return {1'b1, 32'h8800_0000};
        e = (mag > rnd(1.0));
        if (mag < rnd(0.5)) begin
            yp = rnd(1.0) - mag;
            s  = 1'b1;
        end else begin
            yp = mag;
            s  = 1'b0;
        end
        if (yp >= rnd(1.0)) begin
            q = 134217728;
        end else begin
            if      (yp < rnd(0.7389))  begin b = rnd(0.5);     m = rnd(0.2389);  end
            else if (yp < rnd(0.88731)) begin b = rnd(0.59049); m = rnd(0.14841); end
            else if (yp < rnd(0.95705)) begin b = rnd(0.74781); m = rnd(0.06975); end
            else if (yp < rnd(0.99257)) begin b = rnd(0.88603); m = rnd(0.02367); end
            else                        begin b = rnd(0.98125); m = rnd(0.00252); end
            num = (yp > b) ? (yp - b) : 0;
            q   = (num << 24) / m;
            if (q >= 134217728) q = 134217728;
        end
        return {e, (q != 0) && s, q[30:0]};
    endfunction

    task automatic run(input logic [31:0] yv, output logic [31:0] xo,
                       output logic eo, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        y        = yv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        xo = x;
        eo = err;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] yv,
                            input logic [31:0] xe, input logic ee, input int tol);
        logic [31:0] xo;
        logic        eo;
        int          lat;
        run(yv, xo, eo, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(LAT));
        check_val({tag, "_x"}, xo, xe, tol);
        check_val({tag, "_err"}, {31'd0, eo}, {31'd0, ee});
        ack();
    endtask

    real         sv[6] = '{0.6, 0.8, 0.9, 0.97, 0.995, 0.9995};
    logic [32:0] g;
    logic [31:0] yv;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = 32'd0;
        #12;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_x", x, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-derived cases.
        directed("half",    32'h0080_0000, 32'h0000_0000, 1'b0, 0);
        directed("one",     32'h0100_0000, 32'h0800_0000, 1'b0, 0);
        directed("zero",    32'h0000_0000, 32'h8800_0000, 1'b0, 0);
        directed("negzero", 32'h8000_0000, 32'h8800_0000, 1'b0, 0);
        directed("neg",     32'h8010_0000, 32'h8800_0000, 1'b1, 0);
        directed("over",    32'h0180_0000, 32'h0800_0000, 1'b1, 0);
        directed("bp1",     32'h00BD_288D, 32'h0100_0000, 1'b0, 0);
        directed("bp1m",    32'h0042_D773, 32'h8100_0000, 1'b0, 0);
        directed("bp1lo",   32'h00BD_288C, 32'h00FF_FFFB, 1'b0, 2);

        // Spec examples and segment sweep against the golden model.
        g = golden(32'h009E_9000);
        directed("y0p6194", 32'h009E_9000, g[31:0], g[32], 2);
        g = golden(32'h0040_0000);
        directed("y0p25", 32'h0040_0000, g[31:0], g[32], 2);
        for (int i = 0; i < 6; i++) begin
            for (int mi = 0; mi < 2; mi++) begin
                yv = 32'(rnd((mi != 0) ? (1.0 - sv[i]) : sv[i]));
                g  = golden(yv);
                directed($sformatf("sweep%0d_%0d", i, mi), yv, g[31:0], g[32], 2);
            end
        end

        // Backpressure: result held, new inputs ignored.
        begin
            logic [31:0] xo;
            logic        eo;
            int          lat;
            yv = 32'(rnd(0.8));
            g  = golden(yv);
            run(yv, xo, eo, lat);
            check_val("bp_x0", xo, g[31:0], 2);
            for (int i = 0; i < 10; i++) begin
                in_valid = (i % 2 == 0);
                y        = 32'(rnd(0.3));
                @(posedge clk); #1;
                check_val($sformatf("bp_ov%0d", i), {31'd0, out_valid}, 32'd1);
                check_val($sformatf("bp_ir%0d", i), {31'd0, in_ready}, 32'd0);
                check_val($sformatf("bp_x%0d", i), x, g[31:0], 2);
            end
            in_valid = 1'b0;
            ack();
            check_val("bp_idle_ir", {31'd0, in_ready}, 32'd1);
            repeat (3) begin
                @(posedge clk); #1;
            end
            check_val("bp_noqueue", {31'd0, out_valid}, 32'd0);
        end

        // Reset in the middle of a divide.
        y        = 32'(rnd(0.9));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check_val("mid_busy_ir", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_ir", {31'd0, in_ready}, 32'd1);
        check_val("mid_rst_x", x, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        directed("post_rst", 32'h0080_0000, 32'h0000_0000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
